perm_round_ctrl: RTL and testbench

//  Control FSM directly upstream of the permutation-input mux: drives its data_sel_i, the state-register

---
 rtl/perm_round_ctrl.sv | 118 +++++++++++
 tb/tb_perm_round_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/perm_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : perm_round_ctrl
//  Purpose  : Round sequencer for one ASCON permutation, p^a or p^b.
//             Drives the permutation-input mux select, the state-register
//             load enable and the round index for the constant-addition
//             layer. Emits a one-cycle done pulse after the last round.
//  Revision : 1.0  initial release
// ============================================================================
module perm_round_ctrl #(
  parameter int ROUND_W     = 4,
  parameter int NB_ROUNDS_A = 12,
  parameter int NB_ROUNDS_B = 6
) (
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               start_i,
  input  logic               rounds_sel_i,
  output logic               data_sel_o,
  output logic               en_state_o,
  output logic [ROUND_W-1:0] round_o,
  output logic               busy_o,
  output logic               done_o
);

  // Reject round counts that cannot be represented or make no sense.
  generate
    if (!(NB_ROUNDS_B > 0 && NB_ROUNDS_B <= NB_ROUNDS_A &&
          NB_ROUNDS_A <= (1 << ROUND_W))) begin : g_cfg_check
      $error("perm_round_ctrl: illegal round configuration");
    end
  endgenerate

  // Last round index is shared by both permutations; p^b just starts later.
  localparam logic [ROUND_W-1:0] LAST_IDX  = ROUND_W'(NB_ROUNDS_A - 1);
  localparam logic [ROUND_W-1:0] B_START   = ROUND_W'(NB_ROUNDS_A - NB_ROUNDS_B);
  localparam logic [ROUND_W-1:0] A_START   = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [ROUND_W-1:0] counter;
  logic [ROUND_W-1:0] start_idx;

  // Round index a newly accepted permutation begins with.
  assign start_idx = rounds_sel_i ? B_START : A_START;

  // Sequencer with registered Moore outputs, updated together with the state.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state      <= S_IDLE;
      counter    <= '0;
      data_sel_o <= 1'b0;
      en_state_o <= 1'b0;
      round_o    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            // Accept a request; DONE -> FIRST gives back-to-back runs.
            state      <= S_FIRST;
            counter    <= start_idx;
            data_sel_o <= 1'b0;
            en_state_o <= 1'b1;
            round_o    <= start_idx;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
          end else begin
            state      <= S_IDLE;
            counter    <= '0;
            data_sel_o <= 1'b0;
            en_state_o <= 1'b0;
            round_o    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
          end
        end
        S_FIRST, S_ROUND: begin
          // start_i is ignored while a permutation is in flight.
          if (counter == LAST_IDX) begin
            state      <= S_DONE;
            data_sel_o <= 1'b1;
            en_state_o <= 1'b0;
            round_o    <= LAST_IDX;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
          end else begin
            state      <= S_ROUND;
            counter    <= counter + 1'b1;
            data_sel_o <= 1'b1;
            en_state_o <= 1'b1;
            round_o    <= counter + 1'b1;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          counter    <= '0;
          data_sel_o <= 1'b0;
          en_state_o <= 1'b0;
          round_o    <= '0;
          busy_o     <= 1'b0;
          done_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_perm_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_perm_round_ctrl
//  Purpose  : Directed self-checking bench for perm_round_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_perm_round_ctrl;

  logic       clk;
  logic       resetb;
  logic       start;
  logic       rounds_sel;
  logic       data_sel;
  logic       en_state;
  logic [3:0] round;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  perm_round_ctrl #(
    .ROUND_W    (4),
    .NB_ROUNDS_A(12),
    .NB_ROUNDS_B(6)
  ) dut (
    .clock_i     (clk),
    .resetb_i    (resetb),
    .start_i     (start),
    .rounds_sel_i(rounds_sel),
    .data_sel_o  (data_sel),
    .en_state_o  (en_state),
    .round_o     (round),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output vector packed as {data_sel, en_state, busy, done, round}.
  task automatic check_outs(input string tag, input bit ds, input bit en,
                            input bit bz, input bit dn, input int rnd);
    logic [7:0] exp_v;
    exp_v = {ds, en, bz, dn, 4'(rnd)};
    chk(tag, {24'd0, data_sel, en_state, busy, done, round}, {24'd0, exp_v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one permutation from FIRST through DONE. The caller has already
  // driven start/rounds_sel for the accepting edge. hold keeps start high;
  // chain requests the next permutation while in DONE.
  task automatic perm(input string name, input int first, input bit hold,
                      input bit chain, input bit chain_sel);
    for (int r = first; r <= 11; r++) begin
      tick();
      check_outs($sformatf("%s_r%0d", name, r), (r == first) ? 1'b0 : 1'b1,
                 1'b1, 1'b1, 1'b0, r);
      if (!hold) start = 1'b0;
    end
    tick();
    check_outs($sformatf("%s_done", name), 1'b1, 1'b0, 1'b0, 1'b1, 11);
    if (chain) begin
      start      = 1'b1;
      rounds_sel = chain_sel;
    end else if (!hold) begin
      start = 1'b0;
    end
  endtask

  task automatic idle_check(input string tag);
    tick();
    check_outs(tag, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetb     = 1'b1;
    start      = 1'b0;
    rounds_sel = 1'b0;

    // 1: asynchronous reset mid-cycle
    #3 resetb = 1'b0;
    #1 check_outs("reset_async", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick();
    tick();
    check_outs("reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    #3 resetb = 1'b1;
    idle_check("reset_release");
    idle_check("reset_idle2");

    // 2: p^a
    start = 1'b1; rounds_sel = 1'b0;
    perm("pa", 0, 1'b0, 1'b0, 1'b0);
    idle_check("pa_idle");

    // 3: p^b
    start = 1'b1; rounds_sel = 1'b1;
    perm("pb", 6, 1'b0, 1'b0, 1'b0);
    idle_check("pb_idle");

    // 4: start held high through a p^a run
    start = 1'b1; rounds_sel = 1'b0;
    perm("hold", 0, 1'b1, 1'b0, 1'b0);
    perm("hold2", 0, 1'b0, 1'b0, 1'b0);
    idle_check("hold_idle");

    // 5: abort during round 5
    start = 1'b1; rounds_sel = 1'b0;
    tick();
    check_outs("abort_r0", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    start = 1'b0;
    for (int r = 1; r <= 5; r++) begin
      tick();
      check_outs($sformatf("abort_r%0d", r), 1'b1, 1'b1, 1'b1, 1'b0, r);
    end
    #3 resetb = 1'b0;
    #1 check_outs("abort_async", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick();
    check_outs("abort_held", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    #3 resetb = 1'b1;
    idle_check("abort_release");
    idle_check("abort_nodone");
    start = 1'b1; rounds_sel = 1'b0;
    perm("after_abort", 0, 1'b0, 1'b0, 1'b0);
    idle_check("after_abort_idle");

    // 6: back-to-back, p^a then p^b straight from DONE
    start = 1'b1; rounds_sel = 1'b0;
    perm("b2b_a", 0, 1'b0, 1'b1, 1'b1);
    perm("b2b_b", 6, 1'b0, 1'b0, 1'b0);
    idle_check("b2b_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
